// File: rtl/mm_pkg.sv
// Shared definitions for the Mastermind engine: one-hot state encoding and
// the width-derivation helpers used to size ports and counters.
package mm_pkg;

    typedef enum logic [5:0] {
        ST_START  = 6'b000001,
        ST_INPUT  = 6'b000010,
        ST_SCORE  = 6'b000100,
        ST_TALLY  = 6'b001000,
        ST_DONEC  = 6'b010000,
        ST_DONENC = 6'b100000
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int idx_width(input int num_pegs);
        return clog2_min1(num_pegs);
    endfunction

    function automatic int cnt_width(input int num_pegs);
        return $clog2(num_pegs + 1);
    endfunction

    function automatic int gn_width(input int max_guesses);
        return clog2_min1(max_guesses);
    endfunction

endpackage

// File: rtl/mm_histogram.sv
// Per-color counter bank: synchronous clear, single-color increment and an
// asynchronous read port addressed by color.
module mm_histogram
    import mm_pkg::*;
#(
    parameter int COLOR_W = 3,
    parameter int CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    input  logic [COLOR_W-1:0] inc_color,
    input  logic [COLOR_W-1:0] rd_color,
    output logic [CNT_W-1:0]   rd_count
);

    localparam int NUM_COLORS = 2 ** COLOR_W;

    logic [CNT_W-1:0] bins_r [NUM_COLORS];

    // Counter bank: clear has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_COLORS; c++) begin
                bins_r[c] <= CNT_W'(0);
            end
        end else if (clr) begin
            for (int c = 0; c < NUM_COLORS; c++) begin
                bins_r[c] <= CNT_W'(0);
            end
        end else if (inc) begin
            bins_r[inc_color] <= bins_r[inc_color] + CNT_W'(1);
        end
    end

    assign rd_count = bins_r[rd_color];

endmodule

// File: rtl/mastermind_engine.sv
// Mastermind game engine: cursor/peg entry, sequential scoring and tallying.
// Optional per-guess history readback is enabled with MM_HISTORY_EN.
module mastermind_engine
    import mm_pkg::*;
#(
    parameter int NUM_PEGS    = 4,
    parameter int COLOR_W     = 3,
    parameter int MAX_GUESSES = 6,
    localparam int IDX_W  = idx_width(NUM_PEGS),
    localparam int CNT_W  = cnt_width(NUM_PEGS),
    localparam int GN_W   = gn_width(MAX_GUESSES),
    localparam int CODE_W = NUM_PEGS * COLOR_W,
    localparam int HIST_W = CODE_W + 2 * CNT_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [CODE_W-1:0] correct_answer,
    input  logic [COLOR_W-1:0] current_color,
    input  logic              confirm_color,
    input  logic              check_guess,
    input  logic              BtnL,
    input  logic              BtnR,
    input  logic              new_game,
`ifdef MM_HISTORY_EN
    input  logic [GN_W-1:0]   hist_idx,
    output logic [HIST_W-1:0] hist_data,
`endif
    output logic [IDX_W-1:0]  index,
    output logic [GN_W-1:0]   guess_num,
    output logic [CODE_W-1:0] current_guess,
    output logic [CNT_W-1:0]  exact_cnt,
    output logic [CNT_W-1:0]  partial_cnt,
    output logic              score_valid,
    output logic              q_Start,
    output logic              q_Input,
    output logic              q_Score,
    output logic              q_Tally,
    output logic              q_DoneC,
    output logic              q_DoneNC
);

    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_PEGS - 1);
    localparam logic [IDX_W-1:0]   PEG_LAST  = IDX_W'(NUM_PEGS - 1);
    localparam logic [COLOR_W-1:0] COL_LAST  = COLOR_W'((2 ** COLOR_W) - 1);
    localparam logic [GN_W-1:0]    GN_LAST   = GN_W'(MAX_GUESSES - 1);
    localparam logic [CNT_W-1:0]   CNT_ALL   = CNT_W'(NUM_PEGS);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CODE_W-1:0]   target_r;
    logic [IDX_W-1:0]    peg_r;
    logic [COLOR_W-1:0]  col_r;
    logic [CNT_W-1:0]    exact_acc_r;
    logic [CNT_W-1:0]    partial_acc_r;
    logic [COLOR_W-1:0]  guess_peg_s;
    logic [COLOR_W-1:0]  target_peg_s;
    logic [CNT_W-1:0]    ghist_s;
    logic [CNT_W-1:0]    thist_s;
    logic [CNT_W-1:0]    tally_min_s;
    logic                peg_match_s;
    logic                check_ok_s;
    logic                score_last_s;
    logic                tally_last_s;
    logic                win_s;
    logic                last_guess_s;
    logic                hist_clr_s;
    logic                hist_inc_s;

    function automatic logic all_filled(input logic [CODE_W-1:0] code);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_PEGS; i++) begin
            ok = ok & (|code[i*COLOR_W +: COLOR_W]);
        end
        return ok;
    endfunction

    assign guess_peg_s  = current_guess[peg_r*COLOR_W +: COLOR_W];
    assign target_peg_s = target_r[peg_r*COLOR_W +: COLOR_W];
    assign peg_match_s  = (guess_peg_s == target_peg_s);
    assign check_ok_s   = check_guess & all_filled(current_guess);
    assign score_last_s = (peg_r == PEG_LAST);
    assign tally_last_s = (col_r == COL_LAST);
    assign win_s        = (exact_acc_r == CNT_ALL);
    assign last_guess_s = (guess_num == GN_LAST);
    assign tally_min_s  = (ghist_s < thist_s) ? ghist_s : thist_s;

    // Histograms restart at game start and whenever a new guess is accepted
    assign hist_clr_s = (state_r == ST_START) | ((state_r == ST_INPUT) & check_ok_s);
    assign hist_inc_s = (state_r == ST_SCORE) & ~peg_match_s;

    mm_histogram #(.COLOR_W(COLOR_W), .CNT_W(CNT_W)) u_guess_hist (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .clr       (hist_clr_s),
        .inc       (hist_inc_s),
        .inc_color (guess_peg_s),
        .rd_color  (col_r),
        .rd_count  (ghist_s)
    );

    mm_histogram #(.COLOR_W(COLOR_W), .CNT_W(CNT_W)) u_target_hist (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .clr       (hist_clr_s),
        .inc       (hist_inc_s),
        .inc_color (target_peg_s),
        .rd_color  (col_r),
        .rd_count  (thist_s)
    );

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_START;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_START: state_nxt_s = ST_INPUT;
            ST_INPUT: begin
                if (check_ok_s) state_nxt_s = ST_SCORE;
                else            state_nxt_s = ST_INPUT;
            end
            ST_SCORE: begin
                if (score_last_s) state_nxt_s = ST_TALLY;
                else              state_nxt_s = ST_SCORE;
            end
            ST_TALLY: begin
                if (!tally_last_s)     state_nxt_s = ST_TALLY;
                else if (win_s)        state_nxt_s = ST_DONEC;
                else if (last_guess_s) state_nxt_s = ST_DONENC;
                else                   state_nxt_s = ST_INPUT;
            end
            ST_DONEC, ST_DONENC: begin
                if (new_game) state_nxt_s = ST_START;
                else          state_nxt_s = state_r;
            end
            default: state_nxt_s = ST_START;
        endcase
    end

    // Datapath: cursor, peg edits, scoring accumulators and result registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            target_r      <= CODE_W'(0);
            index         <= IDX_W'(0);
            guess_num     <= GN_W'(0);
            current_guess <= CODE_W'(0);
            exact_cnt     <= CNT_W'(0);
            partial_cnt   <= CNT_W'(0);
            score_valid   <= 1'b0;
            peg_r         <= IDX_W'(0);
            col_r         <= COLOR_W'(0);
            exact_acc_r   <= CNT_W'(0);
            partial_acc_r <= CNT_W'(0);
        end else begin
            score_valid <= 1'b0;
            case (state_r)
                ST_START: begin
                    target_r      <= correct_answer;
                    index         <= IDX_W'(0);
                    guess_num     <= GN_W'(0);
                    current_guess <= CODE_W'(0);
                    exact_cnt     <= CNT_W'(0);
                    partial_cnt   <= CNT_W'(0);
                    peg_r         <= IDX_W'(0);
                    col_r         <= COLOR_W'(1);
                    exact_acc_r   <= CNT_W'(0);
                    partial_acc_r <= CNT_W'(0);
                end
                ST_INPUT: begin
                    // The write uses the index before any same-cycle cursor move
                    if (confirm_color) begin
                        current_guess[index*COLOR_W +: COLOR_W] <= current_color;
                    end
                    if (BtnR && !BtnL && (index != IDX_LAST)) begin
                        index <= index + IDX_W'(1);
                    end else if (BtnL && !BtnR && (index != IDX_W'(0))) begin
                        index <= index - IDX_W'(1);
                    end
                    if (check_ok_s) begin
                        peg_r         <= IDX_W'(0);
                        col_r         <= COLOR_W'(1);
                        exact_acc_r   <= CNT_W'(0);
                        partial_acc_r <= CNT_W'(0);
                    end
                end
                ST_SCORE: begin
                    peg_r <= peg_r + IDX_W'(1);
                    if (peg_match_s) begin
                        exact_acc_r <= exact_acc_r + CNT_W'(1);
                    end
                end
                ST_TALLY: begin
                    partial_acc_r <= partial_acc_r + tally_min_s;
                    col_r         <= col_r + COLOR_W'(1);
                    if (tally_last_s) begin
                        exact_cnt   <= exact_acc_r;
                        partial_cnt <= partial_acc_r + tally_min_s;
                        score_valid <= 1'b1;
                        if (state_nxt_s == ST_INPUT) begin
                            guess_num     <= guess_num + GN_W'(1);
                            current_guess <= CODE_W'(0);
                            index         <= IDX_W'(0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MM_HISTORY_EN
    logic [HIST_W-1:0] hist_mem_r [MAX_GUESSES];

    // Guess history: captured at each score, wiped on a new game, read out registered
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int g = 0; g < MAX_GUESSES; g++) begin
                hist_mem_r[g] <= HIST_W'(0);
            end
            hist_data <= HIST_W'(0);
        end else begin
            if (state_r == ST_START) begin
                for (int g = 0; g < MAX_GUESSES; g++) begin
                    hist_mem_r[g] <= HIST_W'(0);
                end
            end else if ((state_r == ST_TALLY) && tally_last_s) begin
                hist_mem_r[guess_num] <= {current_guess, exact_acc_r, partial_acc_r + tally_min_s};
            end
            if (int'(hist_idx) < MAX_GUESSES) begin
                hist_data <= hist_mem_r[hist_idx];
            end else begin
                hist_data <= HIST_W'(0);
            end
        end
    end
`endif

    assign q_Start  = (state_r == ST_START);
    assign q_Input  = (state_r == ST_INPUT);
    assign q_Score  = (state_r == ST_SCORE);
    assign q_Tally  = (state_r == ST_TALLY);
    assign q_DoneC  = (state_r == ST_DONEC);
    assign q_DoneNC = (state_r == ST_DONENC);

endmodule

// File: tb/tb_mastermind_engine.sv
// Self-checking bench for mastermind_engine: directed table, random games
// against a counting reference model, and hand-written corner sequences.
module tb_mastermind_engine;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic [11:0] correct_answer = 12'd0;
    logic [2:0]  current_color = 3'd0;
    logic        confirm_color = 1'b0, check_guess = 1'b0, BtnL = 1'b0, BtnR = 1'b0, new_game = 1'b0;
    logic [1:0]  index;
    logic [2:0]  guess_num;
    logic [11:0] current_guess;
    logic [2:0]  exact_cnt, partial_cnt;
    logic        score_valid, q_Start, q_Input, q_Score, q_Tally, q_DoneC, q_DoneNC;

    logic        r5_n = 1'b1;
    logic [9:0]  ans5 = 10'd0;
    logic [1:0]  col5 = 2'd0;
    logic        conf5 = 1'b0, chk5 = 1'b0, bl5 = 1'b0, br5 = 1'b0, ng5 = 1'b0;
    logic [2:0]  idx5, gn5, ex5, pa5;
    logic [9:0]  cg5;
    logic        sv5, qs5, qi5, qsc5, qt5, qdc5, qdn5;

`ifdef MM_HISTORY_EN
    logic [2:0]  hist_idx = 3'd0, hist_idx5 = 3'd0;
    logic [17:0] hist_data;
    logic [15:0] hist_data5;
`endif

    int n_err = 0;
    int n_chk = 0;

    always #5 Clk = ~Clk;

    mastermind_engine dut (
        .Clk(Clk), .Reset_n(Reset_n), .correct_answer(correct_answer),
        .current_color(current_color), .confirm_color(confirm_color),
        .check_guess(check_guess), .BtnL(BtnL), .BtnR(BtnR), .new_game(new_game),
`ifdef MM_HISTORY_EN
        .hist_idx(hist_idx), .hist_data(hist_data),
`endif
        .index(index), .guess_num(guess_num), .current_guess(current_guess),
        .exact_cnt(exact_cnt), .partial_cnt(partial_cnt), .score_valid(score_valid),
        .q_Start(q_Start), .q_Input(q_Input), .q_Score(q_Score), .q_Tally(q_Tally),
        .q_DoneC(q_DoneC), .q_DoneNC(q_DoneNC)
    );

    mastermind_engine #(.NUM_PEGS(5), .COLOR_W(2), .MAX_GUESSES(6)) dut5 (
        .Clk(Clk), .Reset_n(r5_n), .correct_answer(ans5),
        .current_color(col5), .confirm_color(conf5),
        .check_guess(chk5), .BtnL(bl5), .BtnR(br5), .new_game(ng5),
`ifdef MM_HISTORY_EN
        .hist_idx(hist_idx5), .hist_data(hist_data5),
`endif
        .index(idx5), .guess_num(gn5), .current_guess(cg5),
        .exact_cnt(ex5), .partial_cnt(pa5), .score_valid(sv5),
        .q_Start(qs5), .q_Input(qi5), .q_Score(qsc5), .q_Tally(qt5),
        .q_DoneC(qdc5), .q_DoneNC(qdn5)
    );

    typedef struct {
        logic [11:0] t;
        logic [11:0] g;
        int          ex;
        int          pa;
        int          win;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [11:0] mk(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    // Reference score: exact = positional matches; partial = total common colors minus exact
    function automatic void ref_score(input logic [11:0] t, input logic [11:0] g,
                                      output int ex, output int pa);
        int ht[8];
        int hg[8];
        int tot;
        for (int c = 0; c < 8; c++) begin
            ht[c] = 0;
            hg[c] = 0;
        end
        ex = 0;
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            if (t[i*3 +: 3] == g[i*3 +: 3]) ex++;
            ht[t[i*3 +: 3]]++;
            hg[g[i*3 +: 3]]++;
        end
        for (int c = 1; c < 8; c++) tot += (ht[c] < hg[c]) ? ht[c] : hg[c];
        pa = tot - ex;
    endfunction

    task automatic do_reset(input logic [11:0] t);
        correct_answer = t;
        Reset_n = 1'b0;
        #4;
        Reset_n = 1'b1;
        cyc();
    endtask

    task automatic enter_guess(input logic [11:0] g);
        for (int i = 0; i < 4; i++) begin
            current_color = g[i*3 +: 3];
            confirm_color = 1'b1;
            BtnR = 1'b1;
            cyc();
            confirm_color = 1'b0;
            BtnR = 1'b0;
        end
    endtask

    task automatic score(output int lat);
        check_guess = 1'b1;
        cyc();
        check_guess = 1'b0;
        lat = 0;
        while (score_valid !== 1'b1 && lat < 40) begin
            cyc();
            lat++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, ex, pa, done;
        logic [11:0] t, g;

        vt[0] = '{mk(1,2,3,4), mk(1,2,3,4), 4, 0, 1};
        vt[1] = '{mk(1,1,2,3), mk(1,2,1,4), 1, 2, 0};
        vt[2] = '{mk(1,2,3,4), mk(4,3,2,1), 0, 4, 0};
        vt[3] = '{mk(7,7,7,7), mk(7,1,1,7), 2, 0, 0};
        vt[4] = '{mk(1,1,2,2), mk(2,2,1,1), 0, 4, 0};
        vt[5] = '{mk(1,2,3,4), mk(5,6,7,5), 0, 0, 0};

        // Reset state
        #1;
        Reset_n = 1'b0;
        r5_n = 1'b0;
        #1;
        chk("rst_q_start", q_Start, 1);
        chk("rst_index", index, 0);
        chk("rst_guess", current_guess, 0);
        chk("rst_exact", exact_cnt, 0);
        chk("rst_partial", partial_cnt, 0);
        chk("rst_valid", score_valid, 0);
        cyc();
        chk("rst_hold_start", q_Start, 1);

        // Directed table
        for (int v = 0; v < 6; v++) begin
            do_reset(vt[v].t);
            chk("tbl_input", q_Input, 1);
            enter_guess(vt[v].g);
            score(lat);
            chk("tbl_latency", lat, 11);
            chk("tbl_exact", exact_cnt, vt[v].ex);
            chk("tbl_partial", partial_cnt, vt[v].pa);
            chk("tbl_donec", q_DoneC, vt[v].win);
            if (vt[v].win == 0) begin
                chk("tbl_back_input", q_Input, 1);
                chk("tbl_guess_num", guess_num, 1);
                chk("tbl_guess_clr", current_guess, 0);
                chk("tbl_index_clr", index, 0);
            end
            cyc();
            chk("tbl_valid_pulse", score_valid, 0);
        end

        // Random games against the reference model
        for (int gm = 0; gm < 10; gm++) begin
            for (int i = 0; i < 4; i++) t[i*3 +: 3] = 3'($urandom_range(1, 7));
            do_reset(t);
            done = 0;
            for (int k = 0; k < 6; k++) begin
                if (done == 0) begin
                    for (int i = 0; i < 4; i++) g[i*3 +: 3] = 3'($urandom_range(1, 7));
                    if ($urandom_range(0, 5) == 0) g = t;
                    enter_guess(g);
                    score(lat);
                    ref_score(t, g, ex, pa);
                    chk("rnd_latency", lat, 11);
                    chk("rnd_exact", exact_cnt, ex);
                    chk("rnd_partial", partial_cnt, pa);
                    if (ex == 4) begin
                        chk("rnd_donec", q_DoneC, 1);
                        done = 1;
                    end else if (k == 5) begin
                        chk("rnd_donenc", q_DoneNC, 1);
                        chk("rnd_gn_last", guess_num, 5);
                    end else begin
                        chk("rnd_input", q_Input, 1);
                        chk("rnd_gn", guess_num, k + 1);
                    end
                end
            end
        end

        // Six wrong guesses, hold in DONENC, then new game
        do_reset(mk(1,2,3,4));
        for (int k = 0; k < 6; k++) begin
            enter_guess(mk(5,5,5,5));
            score(lat);
        end
        chk("nc_donenc", q_DoneNC, 1);
        chk("nc_gn", guess_num, 5);
        chk("nc_exact", exact_cnt, 0);
        BtnL = 1'b1; confirm_color = 1'b1; current_color = 3'd1; check_guess = 1'b1;
        cyc();
        BtnL = 1'b0; confirm_color = 1'b0; check_guess = 1'b0;
        cyc();
        chk("nc_hold_state", q_DoneNC, 1);
        chk("nc_hold_index", index, 3);
        chk("nc_hold_guess", current_guess, mk(5,5,5,5));
        new_game = 1'b1;
        cyc();
        new_game = 1'b0;
        chk("ng_start", q_Start, 1);
        cyc();
        chk("ng_input", q_Input, 1);
        chk("ng_gn", guess_num, 0);
        chk("ng_guess", current_guess, 0);

        // Cursor corners
        do_reset(mk(1,2,3,4));
        BtnL = 1'b1; cyc(); BtnL = 1'b0;
        chk("cur_left_at0", index, 0);
        for (int i = 0; i < 5; i++) begin
            BtnR = 1'b1; cyc(); BtnR = 1'b0;
        end
        chk("cur_right_sat", index, 3);
        BtnL = 1'b1; BtnR = 1'b1; cyc(); BtnL = 1'b0; BtnR = 1'b0;
        chk("cur_both", index, 3);
        current_color = 3'd6; confirm_color = 1'b1; BtnL = 1'b1; cyc();
        confirm_color = 1'b0; BtnL = 1'b0;
        chk("cur_wr_old_idx", current_guess, mk(0,0,0,6));
        chk("cur_moved", index, 2);
        for (int i = 0; i < 2; i++) begin
            BtnL = 1'b1; cyc(); BtnL = 1'b0;
        end
        current_color = 3'd1; confirm_color = 1'b1; BtnR = 1'b1; cyc();
        current_color = 3'd2; cyc();
        current_color = 3'd5; cyc();
        current_color = 3'd0; cyc();
        confirm_color = 1'b0; BtnR = 1'b0;
        chk("cur_clear_peg", current_guess, mk(1,2,5,0));

        // Unfilled check ignored; same-cycle fill does not count yet
        check_guess = 1'b1; cyc(); check_guess = 1'b0; cyc();
        chk("chk_unfilled", q_Input, 1);
        current_color = 3'd7; confirm_color = 1'b1; check_guess = 1'b1; cyc();
        confirm_color = 1'b0; check_guess = 1'b0;
        chk("chk_same_cycle", q_Input, 1);
        chk("chk_same_wr", current_guess, mk(1,2,5,7));
        score(lat);
        chk("chk_lat", lat, 11);
        chk("chk_exact", exact_cnt, 2);
        chk("chk_partial", partial_cnt, 0);

        // Reset mid-TALLY
        enter_guess(mk(4,3,2,1));
        check_guess = 1'b1; cyc(); check_guess = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        chk("mt_in_tally", q_Tally, 1);
        Reset_n = 1'b0;
        #1;
        chk("mt_start", q_Start, 1);
        chk("mt_tally_off", q_Tally, 0);
        chk("mt_gn", guess_num, 0);
        chk("mt_guess", current_guess, 0);
        chk("mt_exact", exact_cnt, 0);
        chk("mt_partial", partial_cnt, 0);
        chk("mt_index", index, 0);
        #3;
        Reset_n = 1'b1;
        #1;
        chk("mt_start_rel", q_Start, 1);
        cyc();
        chk("mt_input", q_Input, 1);
        enter_guess(mk(2,1,4,3));
        score(lat);
        chk("mt_post_exact", exact_cnt, 0);
        chk("mt_post_partial", partial_cnt, 4);

        // Five pegs, two-bit colors
        ans5 = {2'd2, 2'd1, 2'd3, 2'd2, 2'd1};
        #3;
        r5_n = 1'b1;
        cyc();
        chk("p5_input", qi5, 1);
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: col5 = 2'd2;
                1: col5 = 2'd1;
                2: col5 = 2'd3;
                3: col5 = 2'd3;
                default: col5 = 2'd2;
            endcase
            conf5 = 1'b1; br5 = 1'b1; cyc();
            conf5 = 1'b0; br5 = 1'b0;
        end
        chk5 = 1'b1; cyc(); chk5 = 1'b0;
        lat = 0;
        while (sv5 !== 1'b1 && lat < 40) begin
            cyc();
            lat++;
        end
        chk("p5_latency", lat, 8);
        chk("p5_exact", ex5, 2);
        chk("p5_partial", pa5, 2);
        chk("p5_gn", gn5, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mastermind_engine.md
MASTERMIND_ENGINE -- requirements
Module: mastermind_engine

Interface
REQ-001 Parameters SHALL be: NUM_PEGS, default 4, pegs per code; COLOR_W, default 3, bits per color (0 = empty); MAX_GUESSES, default 6, guesses allowed.
REQ-002 Derived widths SHALL be: IDX_W=max(1,clog2(NUM_PEGS)); CNT_W=clog2(NUM_PEGS+1); GN_W=max(1,clog2(MAX_GUESSES)); CODE_W=NUM_PEGS*COLOR_W.
REQ-003 Clk  in  1  sole clock, rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 correct_answer  in  CODE_W  target code, peg i at [i*COLOR_W +: COLOR_W]; sampled in START only.
REQ-006 current_color  in  COLOR_W  color from switches.
REQ-007 confirm_color, check_guess, BtnL, BtnR, new_game  in  1 each  single-cycle pulses, already debounced.
REQ-008 index  out  IDX_W  cursor position.
REQ-009 guess_num  out  GN_W  zero-based number of the current guess.
REQ-010 current_guess  out  CODE_W  guess under edit.
REQ-011 exact_cnt, partial_cnt  out  CNT_W each  last score (right color right place / right color wrong place).
REQ-012 score_valid  out  1  one-cycle pulse when exact_cnt/partial_cnt update.
REQ-013 q_Start, q_Input, q_Score, q_Tally, q_DoneC, q_DoneNC  out  1 each  one-hot state flags.

Function
REQ-014 START SHALL last one cycle: latch target, index=0, guess_num=0, current_guess=0, counts=0; go INPUT.
REQ-015 INPUT: BtnR increments index unless index==NUM_PEGS-1; BtnL decrements unless 0; BtnL and BtnR together SHALL leave index unchanged.
REQ-016 INPUT: confirm_color SHALL write current_color to peg[index] next edge, using the pre-move index when a cursor button fires the same cycle; writing 0 clears the peg.
REQ-017 INPUT: check_guess SHALL enter SCORE only if every peg is nonzero; otherwise ignored; a same-cycle confirm_color SHALL still be written and counts toward the fill test only from the next cycle.
REQ-018 SCORE SHALL take NUM_PEGS cycles, one peg per cycle: increment exact on match, else increment per-color histograms for guess and target colors.
REQ-019 TALLY SHALL take 2^COLOR_W-1 cycles over colors 1..max, adding min(guess_hist, target_hist) to partial.
REQ-020 At TALLY end: assert score_valid, update outputs; exact==NUM_PEGS -> DONEC; else guess_num==MAX_GUESSES-1 -> DONENC; else guess_num+1, current_guess=0, index=0, INPUT.
REQ-021 Check-to-score latency SHALL be exactly NUM_PEGS+2^COLOR_W-1 cycles after SCORE entry.
REQ-022 DONEC/DONENC SHALL hold all outputs; new_game SHALL go to START; other inputs ignored there and during SCORE/TALLY.
REQ-023 Counts SHALL never exceed NUM_PEGS; exact+partial<=NUM_PEGS.

Reset
REQ-024 Reset_n low SHALL force START and zero every register and output at once, regardless of state, including mid-SCORE/TALLY; histograms cleared.
REQ-025 First state after Reset_n release SHALL be START.

Configuration
REQ-026 With MM_HISTORY_EN defined: add input hist_idx (GN_W) and output hist_data (CODE_W+2*CNT_W) returning {guess,exact,partial} of guess hist_idx, written at score_valid, cleared in START; without it: ports absent, no history storage.

Structure
REQ-027 Package mm_pkg SHALL hold the one-hot state encoding and the width-derivation functions.
REQ-028 Sub-module mm_histogram (per-color counter bank with clear, increment, read port) SHALL be used twice.

Verification
REQ-029 Defaults, target 1-2-3-4, guess 1-2-3-4, check -> score_valid after 11 cycles, exact=4, partial=0, q_DoneC.
REQ-030 Target 1-1-2-3, guess 1-2-1-4 -> exact=1, partial=2, back to INPUT, guess_num=1, guess cleared.
REQ-031 Six wrong guesses -> after sixth score q_DoneNC, guess_num=5; new_game -> START then INPUT, guess_num=0.
REQ-032 Cursor: BtnL at 0 -> index 0; BtnR x5 -> 3; BtnL+BtnR same cycle -> unchanged; confirm with BtnR -> written at old index.
REQ-033 check_guess with one peg 0 -> stays INPUT; Reset_n low mid-TALLY -> all outputs 0, START on release.
REQ-034 NUM_PEGS=5, COLOR_W=2: target 1-2-3-1-2, guess 2-1-3-3-2 -> exact=2, partial=2, latency 8 cycles.
